// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue/hazard control: per-register pending-write scoreboard, RAW/WAW stalls, redirect squash.
// Optional WB_BYPASS_EN: a same-cycle writeback of the last pending write clears the source hazard.
module decode_issue_ctrl #(
   parameter int NUM_REGS         = 16,
   parameter int REG_IDX_W        = 4,
   parameter int CNT_W            = 2,
   parameter int REDIRECT_BUBBLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inst_valid,
   input  logic [REG_IDX_W-1:0] src1_idx,
   input  logic [REG_IDX_W-1:0] src2_idx,
   input  logic                 uses_src1,
   input  logic                 uses_src2,
   input  logic [REG_IDX_W-1:0] dst_idx,
   input  logic                 reg_wr_en,
   input  logic                 redirect,
   input  logic                 wb_wr_en,
   input  logic [REG_IDX_W-1:0] wb_dst,
   output logic                 stall,
   output logic                 issue,
   output logic                 dbuff_flush,
   output logic                 squashing,
   output logic                 sb_err
);

   localparam int SQ_W = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [SQ_W-1:0]  SQ_RELOAD = SQ_W'(REDIRECT_BUBBLES - 1);

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
   logic [CNT_W-1:0]  cnt_q [NUM_REGS];
   logic [CNT_W-1:0]  cnt_d [NUM_REGS];
   logic              sb_err_q, sb_err_d;
   logic [NUM_REGS-1:0] inc_hit, dec_hit, uflow;

   logic [CNT_W-1:0]  cnt_src1, cnt_src2, cnt_dst;
   logic              byp1, byp2, raw1, raw2, waw, hazard, run;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         sq_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sq_cnt_q <= sq_cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      case (state_q)
         RUN: begin
            if (redirect && (REDIRECT_BUBBLES > 1)) begin
               state_d  = SQUASH;
               sq_cnt_d = SQ_RELOAD;
            end
         end
         SQUASH: begin
            if (redirect) begin
               sq_cnt_d = SQ_RELOAD;
            end else if (sq_cnt_q <= SQ_W'(1)) begin
               state_d  = RUN;
               sq_cnt_d = '0;
            end else begin
               sq_cnt_d = sq_cnt_q - SQ_W'(1);
            end
         end
         default: begin
            state_d  = RUN;
            sq_cnt_d = '0;
         end
      endcase
   end

   // ---------------- hazard detection on registered counts ----------------
   assign cnt_src1 = cnt_q[src1_idx];
   assign cnt_src2 = cnt_q[src2_idx];
   assign cnt_dst  = cnt_q[dst_idx];

`ifdef WB_BYPASS_EN
   // Regfile is write-through, so the final outstanding write landing now satisfies the read.
   assign byp1 = wb_wr_en & (wb_dst == src1_idx) & (cnt_src1 == CNT_W'(1));
   assign byp2 = wb_wr_en & (wb_dst == src2_idx) & (cnt_src2 == CNT_W'(1));
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign raw1   = uses_src1 & (cnt_src1 != '0) & ~byp1;
   assign raw2   = uses_src2 & (cnt_src2 != '0) & ~byp2;
   assign waw    = reg_wr_en & (cnt_dst == CNT_MAX);
   assign hazard = raw1 | raw2 | waw;
   assign run    = (state_q == RUN);

   // ---------------- FSM: outputs ----------------
   always_comb begin
      stall       = 1'b0;
      issue       = 1'b0;
      dbuff_flush = 1'b1;
      squashing   = (state_q == SQUASH);
      sb_err      = sb_err_q;
      if (!reset) begin
         stall       = inst_valid & hazard & ~redirect & run;
         issue       = inst_valid & ~hazard & ~redirect & run;
         dbuff_flush = ~(inst_valid & ~hazard & ~redirect & run);
      end
   end

   // ---------------- scoreboard counters ----------------
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
         assign inc_hit[gi] = issue & reg_wr_en & (dst_idx == REG_IDX_W'(gi));
         assign dec_hit[gi] = wb_wr_en & (wb_dst == REG_IDX_W'(gi));
         assign uflow[gi]   = dec_hit[gi] & (cnt_q[gi] == '0);
         assign cnt_d[gi]   =
            (inc_hit[gi] && !dec_hit[gi] && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + CNT_W'(1) :
            (dec_hit[gi] && !inc_hit[gi] && (cnt_q[gi] != '0))      ? cnt_q[gi] - CNT_W'(1) :
                                                                      cnt_q[gi];
      end
   endgenerate

   assign sb_err_d = sb_err_q | (|uflow);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sb_err_q <= sb_err_d;
      end
   end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Table-driven bench for decode_issue_ctrl: one record per cycle, plus a reset-during-squash sequence.
module tb_decode_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset, inst_valid, uses_src1, uses_src2, reg_wr_en, redirect, wb_wr_en;
   logic [3:0] src1_idx, src2_idx, dst_idx, wb_dst;
   logic       stall, issue, dbuff_flush, squashing, sb_err;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   decode_issue_ctrl #(
      .NUM_REGS(16), .REG_IDX_W(4), .CNT_W(2), .REDIRECT_BUBBLES(2)
   ) dut (
      .clk(clk), .reset(reset), .inst_valid(inst_valid),
      .src1_idx(src1_idx), .src2_idx(src2_idx),
      .uses_src1(uses_src1), .uses_src2(uses_src2),
      .dst_idx(dst_idx), .reg_wr_en(reg_wr_en), .redirect(redirect),
      .wb_wr_en(wb_wr_en), .wb_dst(wb_dst),
      .stall(stall), .issue(issue), .dbuff_flush(dbuff_flush),
      .squashing(squashing), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, iv, u1, u2, wr, rd, wbe;
      logic [3:0] s1, s2, d, wbd;
      logic       st, is, fl, sq, er;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic iv,
                      input logic u1, input logic [3:0] s1,
                      input logic u2, input logic [3:0] s2,
                      input logic wr, input logic [3:0] d,
                      input logic rd, input logic wbe, input logic [3:0] wbd,
                      input logic st, input logic is, input logic fl,
                      input logic sq, input logic er);
      vec_t v;
      v.rst = rst; v.iv = iv; v.u1 = u1; v.s1 = s1; v.u2 = u2; v.s2 = s2;
      v.wr = wr; v.d = d; v.rd = rd; v.wbe = wbe; v.wbd = wbd;
      v.st = st; v.is = is; v.fl = fl; v.sq = sq; v.er = er;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; inst_valid = v.iv;
      uses_src1 = v.u1; src1_idx = v.s1; uses_src2 = v.u2; src2_idx = v.s2;
      reg_wr_en = v.wr; dst_idx = v.d; redirect = v.rd;
      wb_wr_en = v.wbe; wb_dst = v.wbd;
   endtask

   task automatic chk1(input string name, input int row, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL row %0d %s: got %b expected %b", row, name, act, exp);
      end
   endtask

   task automatic check(input int row, input vec_t v);
      chk1("stall", row, stall, v.st);
      chk1("issue", row, issue, v.is);
      chk1("dbuff_flush", row, dbuff_flush, v.fl);
      chk1("squashing", row, squashing, v.sq);
      chk1("sb_err", row, sb_err, v.er);
      $display("row %0d: rst=%b iv=%b rd=%b wb=%b/%0d -> stall=%b issue=%b flush=%b sq=%b err=%b",
               row, v.rst, v.iv, v.rd, v.wbe, v.wbd, stall, issue, dbuff_flush, squashing, sb_err);
   endtask

   initial begin
      vec_t v;
      //   rst iv  u1 s1  u2 s2  wr d   rd wbe wbd   st  is  fl  sq  er
      // reset holds issue off even with a valid writing instruction
      add(1, 1,  1, 3,  0, 0,  1, 3,  0, 0, 0,    0,  0,  1,  0,  0); // 0
      // RAW on R3
      add(0, 1,  1, 3,  0, 0,  1, 3,  0, 0, 0,    0,  1,  0,  0,  0); // 1 issue wr R3
      add(0, 1,  1, 3,  0, 0,  0, 0,  0, 0, 0,    1,  0,  1,  0,  0); // 2
      add(0, 1,  1, 3,  0, 0,  0, 0,  0, 0, 0,    1,  0,  1,  0,  0); // 3
      add(0, 1,  1, 3,  0, 0,  0, 0,  0, 1, 3,   ~BYP, BYP, ~BYP, 0, 0); // 4 wb R3
      add(0, 1,  1, 3,  0, 0,  0, 0,  0, 0, 0,    0,  1,  0,  0,  0); // 5
      // WAW saturation on R5
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 0, 0,    0,  1,  0,  0,  0); // 6
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 0, 0,    0,  1,  0,  0,  0); // 7
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 0, 0,    0,  1,  0,  0,  0); // 8
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 0, 0,    1,  0,  1,  0,  0); // 9
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 1, 5,    1,  0,  1,  0,  0); // 10 wb R5
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 0, 0,    0,  1,  0,  0,  0); // 11 released
      add(0, 1,  0, 0,  0, 0,  1, 5,  0, 0, 0,    1,  0,  1,  0,  0); // 12 count back at 3
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 5,    0,  0,  1,  0,  0); // 13
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 5,    0,  0,  1,  0,  0); // 14
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 5,    0,  0,  1,  0,  0); // 15
      add(0, 1,  1, 5,  0, 0,  0, 0,  0, 0, 0,    0,  1,  0,  0,  0); // 16 R5 drained
      // simultaneous inc/dec on R7
      add(0, 1,  0, 0,  0, 0,  1, 7,  0, 0, 0,    0,  1,  0,  0,  0); // 17
      add(0, 1,  0, 0,  0, 0,  1, 7,  0, 1, 7,    0,  1,  0,  0,  0); // 18
      add(0, 1,  1, 0,  1, 7,  0, 0,  0, 0, 0,    1,  0,  1,  0,  0); // 19 src2 RAW
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 7,    0,  0,  1,  0,  0); // 20
      add(0, 1,  0, 0,  1, 7,  0, 0,  0, 0, 0,    0,  1,  0,  0,  0); // 21
      // underflow on R9
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 9,    0,  0,  1,  0,  0); // 22
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 0,    0,  0,  1,  0,  1); // 23
      add(0, 1,  1, 9,  0, 0,  0, 0,  0, 0, 0,    0,  1,  0,  0,  1); // 24
      add(0, 1,  0, 0,  0, 0,  1, 2,  0, 0, 0,    0,  1,  0,  0,  1); // 25 pending R2
      add(1, 1,  1, 2,  0, 0,  0, 0,  0, 0, 0,    0,  0,  1,  0,  1); // 26 reset mid-stall
      add(0, 1,  1, 2,  0, 0,  0, 0,  0, 0, 0,    0,  1,  0,  0,  0); // 27
      // redirect / squash
      add(0, 1,  0, 0,  0, 0,  1, 4,  1, 0, 0,    0,  0,  1,  0,  0); // 28 redirect
      add(0, 1,  0, 0,  0, 0,  1, 6,  0, 0, 0,    0,  0,  1,  1,  0); // 29
      add(0, 1,  0, 0,  0, 0,  1, 4,  0, 0, 0,    0,  1,  0,  0,  0); // 30
      add(0, 1,  1, 4,  0, 0,  0, 0,  1, 0, 0,    0,  0,  1,  0,  0); // 31 redirect hides RAW
      add(0, 1,  1, 4,  0, 0,  0, 0,  1, 0, 0,    0,  0,  1,  1,  0); // 32 redirect reloads
      add(0, 1,  1, 4,  0, 0,  0, 0,  0, 0, 0,    0,  0,  1,  1,  0); // 33
      add(0, 1,  1, 4,  0, 0,  0, 0,  0, 0, 0,    1,  0,  1,  0,  0); // 34
      add(0, 0,  0, 0,  0, 0,  0, 0,  0, 1, 4,    0,  0,  1,  0,  0); // 35
      add(0, 1,  1, 4,  1, 6,  0, 0,  0, 0, 0,    0,  1,  0,  0,  0); // 36 no leaked counts

      // bring-up reset, unchecked first edge
      v = vecs[0];
      v.wr = 1'b0; v.u1 = 1'b0;
      @(negedge clk);
      drive(v);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i]);
         #1;
         check(i, vecs[i]);
      end

      // reset while squashing returns straight to RUN
      v = vecs[28];
      @(negedge clk); drive(v); #1; check(100, v);
      v = vecs[27]; v.rst = 1'b1; v.st = 1'b0; v.is = 1'b0; v.fl = 1'b1; v.sq = 1'b1; v.er = 1'b0;
      @(negedge clk); drive(v); #1; check(101, v);
      v = vecs[27];
      @(negedge clk); drive(v); #1; check(102, v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
